// File: rtl/pq_autotest_seq_if.sv
// Bus between the traffic sequencer and the priority queue under test.
//
// Request protocol: the sequencer raises at most one of pq_enq / pq_deq,
// for a single cycle, and only while pq_busy is low. pq_kvi carries data
// only in the cycle pq_enq is high and is zero otherwise. The queue takes
// every request it sees, may raise pq_busy from the following cycle, and
// pq_kvo / pq_full / pq_empty are meaningful whenever pq_busy is low.
interface pq_autotest_seq_if #(
    parameter int W = 16
);
    logic [W-1:0] pq_kvi;
    logic         pq_enq;
    logic         pq_deq;
    logic [W-1:0] pq_kvo;
    logic         pq_full;
    logic         pq_empty;
    logic         pq_busy;

    modport master (
        output pq_kvi, pq_enq, pq_deq,
        input  pq_kvo, pq_full, pq_empty, pq_busy
    );

    modport slave (
        input  pq_kvi, pq_enq, pq_deq,
        output pq_kvo, pq_full, pq_empty, pq_busy
    );
endinterface

// File: rtl/pq_autotest_seq.sv
// Self-checking traffic sequencer for a priority queue: feeds LFSR-derived
// key/value pairs, drains the queue, flags out-of-order dequeues, count
// mismatches and busy timeouts, and reports the outcome on status/LED pins.
module pq_autotest_seq #(
    parameter int          KW      = 8,
    parameter int          VW      = 8,
    parameter int          N_ITEMS = 15,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    pq_autotest_seq_if.master pq,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [15:0]       deq_cnt,
    output logic [2:0]        led_rgb,
    output logic [2:0]        dbg_state
);
    localparam int          KVW       = KW + VW;
    localparam logic [15:0] N_LAST    = 16'(N_ITEMS);
    // Abort on the TIMEOUT-th consecutive waiting cycle, so busy is never
    // tolerated for more than TIMEOUT cycles after a request.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // taps 16,14,13,11

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [15:0]    lfsr, lfsr_step;
    logic [KVW-1:0] lfsr_kv;
    logic [KW-1:0]  floor_key, chk_key, head_key, new_key;
    logic [15:0]    enq_cnt, ok_cnt, timer;
    logic           mode_q, last_deq;
    logic [1:0]     phase;
    logic           issue_act, want_enq, all_enq;
    logic           do_enq, skip_enq, do_deq, skip_deq, drain_end;
    logic           wait_busy, wait_exit, timeout, chk_err, start_ok, cnt_err, err_inc;
    logic [VW-1:0]  unused_kvo_value;

    assign lfsr_step        = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign head_key         = pq.pq_kvo[KVW-1 -: KW];
    assign new_key          = lfsr_kv[KVW-1 -: KW];
    assign unused_kvo_value = pq.pq_kvo[VW-1:0];

    generate
        if (KVW <= 16) begin : g_kv_narrow
            assign lfsr_kv = lfsr[KVW-1:0];
        end else begin : g_kv_wide
            assign lfsr_kv = {{(KVW-16){1'b0}}, lfsr};
        end
    endgenerate

    // Per-cycle decisions: what ISSUE does this cycle, how WAIT resolves, error sources.
    always_comb begin
        start_ok  = start && (state == S_IDLE || state == S_DONE);
        issue_act = (state == S_ISSUE) && !pq.pq_busy;
        all_enq   = (enq_cnt == N_LAST);
        // Interleaved mode runs enq, enq, deq while enqueues remain.
        want_enq  = (enq_cnt < N_LAST) && (!mode_q || phase != 2'd2);
        do_enq    = issue_act &&  want_enq && !pq.pq_full;
        skip_enq  = issue_act &&  want_enq &&  pq.pq_full;
        do_deq    = issue_act && !want_enq && !pq.pq_empty;
        drain_end = issue_act && !want_enq &&  pq.pq_empty &&  all_enq;
        skip_deq  = issue_act && !want_enq &&  pq.pq_empty && !all_enq;
        // The first WAIT cycle (timer still 0) is always spent waiting.
        wait_busy = (state == S_WAIT) && (timer == 16'd0 || pq.pq_busy);
        wait_exit = (state == S_WAIT) && !wait_busy;
        timeout   = wait_busy && (timer == TMO_LAST);
        chk_err   = (state == S_CHECK) && (chk_key < floor_key);
        cnt_err   = drain_end && (deq_cnt != ok_cnt);
        err_inc   = skip_enq || skip_deq || timeout || chk_err || cnt_err;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (drain_end)             state_nxt = S_DONE;
                else if (do_enq || do_deq) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (timeout)        state_nxt = S_DONE;
                else if (wait_exit) state_nxt = last_deq ? S_CHECK : S_ISSUE;
            end
            S_CHECK: state_nxt = S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: LFSR, ordering floor, counters and busy timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= SEED;
            floor_key <= '0;
            chk_key   <= '0;
            enq_cnt   <= '0;
            ok_cnt    <= '0;
            deq_cnt   <= '0;
            err_cnt   <= '0;
            timer     <= '0;
            mode_q    <= 1'b0;
            last_deq  <= 1'b0;
            phase     <= '0;
        end else if (start_ok) begin
            lfsr      <= SEED;
            floor_key <= '0;
            chk_key   <= '0;
            enq_cnt   <= '0;
            ok_cnt    <= '0;
            deq_cnt   <= '0;
            err_cnt   <= '0;
            timer     <= '0;
            mode_q    <= mode;
            last_deq  <= 1'b0;
            phase     <= '0;
        end else begin
            if (do_enq || skip_enq) begin
                lfsr    <= lfsr_step;
                enq_cnt <= enq_cnt + 16'd1;
                phase   <= phase + 2'd1;
            end
            if (do_enq) begin
                ok_cnt   <= ok_cnt + 16'd1;
                last_deq <= 1'b0;
                // A fresh key below the floor legitimately lowers it.
                if (new_key < floor_key) floor_key <= new_key;
            end
            if (do_deq) begin
                chk_key  <= head_key;
                last_deq <= 1'b1;
            end
            if (do_deq || skip_deq) phase <= '0;
            if (wait_exit)                 timer <= '0;
            else if (wait_busy && !timeout) timer <= timer + 16'd1;
            if (state == S_CHECK) begin
                floor_key <= chk_key;
                deq_cnt   <= deq_cnt + 16'd1;
            end
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    // Outputs: request pulses, status flags and LED code.
    always_comb begin
        pq.pq_enq = do_enq;
        pq.pq_deq = do_deq;
        pq.pq_kvi = do_enq ? lfsr_kv : '0;
        running   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
        done      = (state == S_DONE);
        pass      = (state == S_DONE) && (err_cnt == 8'd0);
        if (running)                        led_rgb = 3'b001;
        else if (state == S_DONE && pass)   led_rgb = 3'b010;
        else if (state == S_DONE)           led_rgb = 3'b100;
        else                                led_rgb = 3'b000;
        dbg_state = state;
    end
endmodule
